// File: rtl/fifo_framer.sv
// Purpose: frames words from a read-side FIFO as header {SYNC_BYTE,seq}, FRAME_LEN payload words, checksum trailer.
// Latency: read request at N, capture at N+1, header valid at N+2, first payload word at N+3.
// Backpressure: out_valid/out_ready handshake; outputs hold while stalled; reads stop when the 2-entry buffer is committed.
module fifo_framer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  read_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_data_valid,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [15:0]           frame_count,
    output logic                  overrun_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_TRAILER = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t                r_state;
    logic [1:0]            r_occ;
    logic                  r_inf;
    logic                  r_rst_d;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [7:0]            r_seq;
    logic [7:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [15:0]           r_fc;
    logic                  r_ovr;

    logic [1:0]            w_level;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_hdr;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic                  w_out_last;
    logic                  w_xfer;
    logic                  w_push;
    logic                  w_pop;

    // Words already buffered plus the one possibly in flight bound how many more we may request.
    assign w_level = r_occ + {1'b0, r_inf};
    assign w_rd_en = enable & ~fifo_empty & (w_level < 2'd2) & ~reset & ~r_rst_d;

    assign w_push = fifo_data_valid;
    assign w_xfer = w_out_valid & out_ready;
    assign w_pop  = (r_state == S_PAYLOAD) & w_xfer;

    // Header word: sync byte in the top byte, sequence number in the bottom byte.
    always_comb begin
        w_hdr                    = '0;
        w_hdr[DATA_WIDTH-1 -: 8] = SYNC_BYTE;
        w_hdr[7:0]               = r_seq;
    end

    // Output decode from the registered state and buffer head; forced quiet while reset is high.
    always_comb begin
        w_out_valid = 1'b0;
        w_out_data  = '0;
        w_out_last  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_HEADER: begin
                    w_out_valid = 1'b1;
                    w_out_data  = w_hdr;
                end
                S_PAYLOAD: begin
                    w_out_valid = (r_occ != 2'd0);
                    w_out_data  = r_buf0;
                end
                S_TRAILER: begin
                    w_out_valid = 1'b1;
                    w_out_data  = r_sum;
                    w_out_last  = 1'b1;
                end
                default: begin
                    w_out_valid = 1'b0;
                end
            endcase
        end
    end

    assign fifo_read_enable = w_rd_en;
    assign out_valid        = w_out_valid;
    assign out_data         = w_out_data;
    assign out_last         = w_out_last;
    assign frame_count      = r_fc;
    assign overrun_error    = r_ovr;

    // Track the outstanding read and remember reset for one cycle so no read fires right after it.
    always_ff @(posedge read_clk) begin
        if (reset) begin
            r_inf   <= 1'b0;
            r_rst_d <= 1'b1;
        end else begin
            r_inf   <= w_rd_en;
            r_rst_d <= 1'b0;
        end
    end

    // Two-entry prefetch buffer, head in r_buf0; a push into a full buffer without a pop is lost.
    always_ff @(posedge read_clk) begin
        if (reset) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
            r_ovr  <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_data;
                    end else begin
                        r_buf0 <= fifo_data;
                    end
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= fifo_data;
                        r_occ  <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_buf1 <= fifo_data;
                        r_occ  <= 2'd2;
                    end else begin
                        r_ovr  <= 1'b1;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

    // Frame sequencer: header, FRAME_LEN payload words with running checksum, trailer.
    always_ff @(posedge read_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_seq   <= 8'd0;
            r_cnt   <= 8'd0;
            r_sum   <= '0;
            r_fc    <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A word landing this cycle counts, so the header can appear one cycle earlier.
                    if (enable && ((r_occ != 2'd0) || w_push)) begin
                        r_state <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (w_xfer) begin
                        r_cnt   <= 8'd0;
                        r_sum   <= '0;
                        r_state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        r_sum <= r_sum + r_buf0;
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_TRAILER;
                        end
                    end
                end
                S_TRAILER: begin
                    if (w_xfer) begin
                        r_seq   <= r_seq + 8'd1;
                        if (r_fc != 16'hFFFF) begin
                            r_fc <= r_fc + 16'd1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_framer.sv
// Purpose: scoreboard bench for fifo_framer with FRAME_LEN=4 against a one-cycle-latency FIFO model.
// Latency: checks header two cycles after the first read request; outputs sampled on the falling edge.
// Backpressure: out_ready steady, random, or held low 10 cycles per word kind; stall stability checked.
module tb_fifo_framer;

    localparam int DW = 16;
    localparam int FL = 4;
    localparam int K_HDR = 0;
    localparam int K_PL  = 1;
    localparam int K_TRL = 2;

    logic          read_clk;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_data_valid;
    logic          fifo_read_enable;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [15:0]   frame_count;
    logic          overrun_error;

    typedef struct {
        logic [15:0] d;
        logic        last;
        int          kind;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] src_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  seq_m   = 8'd0;
    int          fc_exp  = 0;
    int          rd_cnt  = 0;
    int          pop_cnt = 0;
    int          pl_total = 0;
    int          hdr_cnt = 0;
    logic [15:0] last_hdr = 16'h0;
    int          rmode   = 0;
    logic        inj     = 1'b0;
    logic [15:0] inj_dat = 16'h0;
    bit          stalled_kind[3];
    logic        stall_v = 1'b0;
    logic [15:0] stall_d = 16'h0;
    logic        stall_l = 1'b0;

    fifo_framer #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FL),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .read_clk         (read_clk),
        .reset            (reset),
        .enable           (enable),
        .fifo_empty       (fifo_empty),
        .fifo_data        (fifo_data),
        .fifo_data_valid  (fifo_data_valid),
        .fifo_read_enable (fifo_read_enable),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .frame_count      (frame_count),
        .overrun_error    (overrun_error)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge read_clk);
        #2;
    endtask

    // Queue one frame's payload at the source and its full expected output at the scoreboard.
    task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        logic [15:0] w[4];
        logic [15:0] s;
        exp_t        e;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        s = 16'h0;
        e.d = {8'hA5, seq_m}; e.last = 1'b0; e.kind = K_HDR;
        exp_q.push_back(e);
        for (int i = 0; i < FL; i++) begin
            src_q.push_back(w[i]);
            s = s + w[i];
            e.d = w[i]; e.last = 1'b0; e.kind = K_PL;
            exp_q.push_back(e);
        end
        e.d = s; e.last = 1'b1; e.kind = K_TRL;
        exp_q.push_back(e);
        seq_m = seq_m + 8'd1;
        fc_exp++;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        chk("drain", exp_q.size(), 0);
        tick();
    endtask

    // Upstream FIFO: a request seen in one cycle returns data in the next.
    initial begin : fifo_model
        logic rd;
        fifo_data_valid = 1'b0;
        fifo_data       = '0;
        fifo_empty      = 1'b1;
        forever begin
            @(negedge read_clk);
            rd = fifo_read_enable;
            @(posedge read_clk);
            #1;
            if (rd && src_q.size() > 0) begin
                fifo_data       = src_q.pop_front();
                fifo_data_valid = 1'b1;
            end else if (inj) begin
                fifo_data       = inj_dat;
                fifo_data_valid = 1'b1;
            end else begin
                fifo_data_valid = 1'b0;
            end
            fifo_empty = (src_q.size() == 0);
        end
    end

    // Downstream acceptance: steady, forced low, or random with one 10-cycle stall per word kind.
    initial begin : ready_drv
        int stall_left;
        stall_left = 0;
        out_ready  = 1'b1;
        forever begin
            @(posedge read_clk);
            #1;
            if (rmode == 0) begin
                out_ready = 1'b1;
            end else if (rmode == 2) begin
                out_ready = 1'b0;
            end else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (out_valid && exp_q.size() > 0 && !stalled_kind[exp_q[0].kind]) begin
                stalled_kind[exp_q[0].kind] = 1'b1;
                stall_left = 9;
                out_ready  = 1'b0;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Output monitor: scoreboard compare, stall stability, and read-request bound.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge read_clk);
            if (reset) begin
                rd_cnt  = 0;
                pop_cnt = 0;
                stall_v = 1'b0;
            end else begin
                if (stall_v) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, stall_d);
                    chk("hold_last", out_last, stall_l);
                end
                if (fifo_read_enable) chk("rd_level", (rd_cnt - pop_cnt) < 2, 1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_last", out_last, e.last);
                        if (e.kind == K_PL) begin
                            pop_cnt++;
                            pl_total++;
                        end
                        if (e.kind == K_HDR) begin
                            hdr_cnt++;
                            last_hdr = out_data;
                        end
                    end
                end
                stall_v = out_valid && !out_ready;
                stall_d = out_data;
                stall_l = out_last;
                if (fifo_read_enable) rd_cnt++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int base;
        int h0;
        int nfr;
        reset  = 1'b1;
        enable = 1'b1;
        tick();
        send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_rd", fifo_read_enable, 0);
        chk("rst_data", out_data, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_ovr", overrun_error, 0);

        // First cycle after reset: data is waiting but nothing may be requested or shown yet.
        reset = 1'b0;
        #1;
        chk("post_rst_rd", fifo_read_enable, 0);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_data", out_data, 0);

        for (int i = 0; i < 20 && !fifo_read_enable; i++) tick();
        chk("rd_start", fifo_read_enable, 1);
        lat = 0;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            tick();
            lat++;
        end
        chk("hdr_latency", lat, 2);
        wait_drain(200);
        chk("fc_first", frame_count, fc_exp);

        send_frame(16'h0010, 16'h0011, 16'h0012, 16'h0013);
        send_frame(16'h0014, 16'h0015, 16'h0016, 16'h0017);
        wait_drain(400);
        chk("fc_two", frame_count, fc_exp);

        send_frame(16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000);
        wait_drain(200);
        chk("fc_wrap", frame_count, fc_exp);

        for (int k = 0; k < 3; k++) stalled_kind[k] = 1'b0;
        rmode = 1;
        for (int f = 0; f < 6; f++)
            send_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        wait_drain(4000);
        rmode = 0;
        chk("stall_hdr_seen", stalled_kind[K_HDR], 1);
        chk("stall_trl_seen", stalled_kind[K_TRL], 1);
        chk("ovr_random", overrun_error, 0);
        chk("fc_random", frame_count, fc_exp);

        // Drop enable after the second payload word; no header may start while it is low.
        base = pl_total;
        send_frame(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        send_frame(16'h0500, 16'h0600, 16'h0700, 16'h0800);
        for (int i = 0; i < 200 && pl_total < base + 2; i++) tick();
        chk("en_wait", pl_total >= base + 2, 1);
        enable = 1'b0;
        h0 = hdr_cnt;
        repeat (30) tick();
        chk("no_hdr_en0", hdr_cnt, h0);
        chk("no_rd_en0", fifo_read_enable, 0);
        enable = 1'b1;
        wait_drain(400);
        chk("fc_enable", frame_count, fc_exp);

        nfr = 256 - int'(seq_m);
        for (int f = 0; f < nfr; f++)
            send_frame(16'(f), 16'(f + 1), 16'(3 * f), 16'hBEEF);
        wait_drain(10000);
        send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        wait_drain(200);
        chk("seq_wrap_hdr", last_hdr, 16'hA500);
        chk("fc_many", frame_count, fc_exp);
        chk("ovr_clean", overrun_error, 0);

        // Force a third word into a full buffer while idle and disabled.
        enable  = 1'b0;
        inj_dat = 16'hDEAD;
        inj     = 1'b1;
        repeat (3) tick();
        inj = 1'b0;
        tick();
        tick();
        chk("ovr_set", overrun_error, 1);
        reset = 1'b1;
        exp_q.delete();
        src_q.delete();
        seq_m  = 8'd0;
        fc_exp = 0;
        tick();
        reset = 1'b0;
        tick();
        chk("ovr_rst", overrun_error, 0);

        // Reset in the middle of the payload abandons the frame.
        enable = 1'b1;
        base = pl_total;
        send_frame(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        for (int i = 0; i < 200 && pl_total < base + 1; i++) tick();
        chk("rstmid_wait", pl_total >= base + 1, 1);
        reset = 1'b1;
        exp_q.delete();
        src_q.delete();
        seq_m  = 8'd0;
        fc_exp = 0;
        #1;
        chk("rstmid_valid_in", out_valid, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rstmid_valid_after", out_valid, 0);
        chk("rstmid_last_after", out_last, 0);
        chk("rstmid_fc", frame_count, 0);
        tick();
        send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        wait_drain(200);
        chk("rstmid_next_hdr", last_hdr, 16'hA500);
        chk("rstmid_fc_next", frame_count, fc_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
